// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 result writer.
//   - HD44780 command bytes used by the init and write sequences
//   - top-level FSM state encoding
//   - hex_to_ascii: 4-bit nibble to uppercase ASCII hex digit
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

    localparam logic [4:0] INIT_BYTES   = 5'd4;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};  // 10 -> 'A' (0x41)
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One-byte strobe/wait engine for the HD44780 parallel bus.
// A byte accepted on go (while ready) is placed on lcd_rs/lcd_db the next
// cycle, lcd_e is raised one cycle later for E_HIGH_CYC cycles, then the
// engine waits CLEAR_CYC (clear command) or SETTLE_CYC before ready returns.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   go              issue the byte on rs/data (only honoured while ready)
//   rs, data        register select and byte to send
//   is_clear        byte is the slow clear command
//   ready           engine idle, next byte may be issued this cycle
//   last            final cycle of the post-strobe wait
//   lcd_rs, lcd_e, lcd_db   LCD bus outputs (registered)
module lcd_byte_tx #(
    parameter int unsigned E_HIGH_CYC = 12,
    parameter int unsigned SETTLE_CYC = 2_500,
    parameter int unsigned CLEAR_CYC  = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       is_clear,
    output logic       ready,
    output logic       last,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;  // bus driven, E still low
    localparam logic [1:0] PH_STROBE = 2'd2;  // E high
    localparam logic [1:0] PH_WAIT   = 2'd3;  // E low, controller executing

    logic [1:0]  phase_reg;
    logic [31:0] cnt_reg;
    logic        clear_reg;
    logic        rs_reg;
    logic        e_reg;
    logic [7:0]  db_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg <= PH_IDLE;
            cnt_reg   <= '0;
            clear_reg <= 1'b0;
            rs_reg    <= 1'b0;
            e_reg     <= 1'b0;
            db_reg    <= 8'h00;
        end else begin
            case (phase_reg)
                PH_IDLE: begin
                    if (go) begin
                        rs_reg    <= rs;
                        db_reg    <= data;
                        clear_reg <= is_clear;
                        phase_reg <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    e_reg     <= 1'b1;
                    cnt_reg   <= E_HIGH_CYC - 1;
                    phase_reg <= PH_STROBE;
                end
                PH_STROBE: begin
                    if (cnt_reg == '0) begin
                        e_reg     <= 1'b0;
                        cnt_reg   <= clear_reg ? (CLEAR_CYC - 1) : (SETTLE_CYC - 1);
                        phase_reg <= PH_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg - 1;
                    end
                end
                default: begin
                    // rs/db stay put through the wait, giving the hold time
                    if (cnt_reg == '0) begin
                        phase_reg <= PH_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1;
                    end
                end
            endcase
        end
    end

    assign ready  = (phase_reg == PH_IDLE);
    assign last   = (phase_reg == PH_WAIT) && (cnt_reg == '0);
    assign lcd_rs = rs_reg;
    assign lcd_e  = e_reg;
    assign lcd_db = db_reg;

endmodule

// File: rtl/lcd_result_writer.sv
// HD44780 character-LCD writer for the logic-instruction unit.
// After reset it waits POWERUP_CYC, runs the init commands, then on each
// accepted start renders "S=<sel> R=<result hex>" on line 1.
// Optional feature macro LCD_BIN_LINE_EN: additionally writes result in
// binary ('0'/'1', MSB first) on line 2.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           update request, accepted only in IDLE
//   sel[3:0]        opcode select to display
//   result[7:0]     logic-unit result to display
//   busy            high while initialising or writing (low only in IDLE)
//   done            one-cycle pulse when an update finishes
//   lcd_rs, lcd_rw, lcd_e, lcd_db[7:0]   HD44780 8-bit parallel bus
module lcd_result_writer #(
    parameter int unsigned POWERUP_CYC = 1_000_000,
    parameter int unsigned E_HIGH_CYC  = 12,
    parameter int unsigned SETTLE_CYC  = 2_500,
    parameter int unsigned CLEAR_CYC   = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] sel,
    input  logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    import lcd_pkg::*;

`ifdef LCD_BIN_LINE_EN
    localparam logic [4:0] NBYTES = 5'd18;
`else
    localparam logic [4:0] NBYTES = 5'd9;
`endif

    state_t      state_reg;
    logic [31:0] pwr_cnt_reg;
    logic [4:0]  idx_reg;      // bytes already issued in the current sequence
    logic [3:0]  sel_reg;
    logic [7:0]  result_reg;

    logic        tx_go;
    logic        tx_rs;
    logic [7:0]  tx_data;
    logic        tx_clear;
    logic        tx_ready;
    logic        tx_last;

    logic [7:0]  line1_char [0:7];

    always_comb begin
        line1_char[0] = 8'h53;                        // 'S'
        line1_char[1] = 8'h3D;                        // '='
        line1_char[2] = hex_to_ascii(sel_reg);
        line1_char[3] = 8'h20;                        // ' '
        line1_char[4] = 8'h52;                        // 'R'
        line1_char[5] = 8'h3D;                        // '='
        line1_char[6] = hex_to_ascii(result_reg[7:4]);
        line1_char[7] = hex_to_ascii(result_reg[3:0]);
    end

`ifdef LCD_BIN_LINE_EN
    logic [7:0] bin_char [0:7];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bin
            assign bin_char[gi] = result_reg[7-gi] ? 8'h31 : 8'h30;
        end
    endgenerate
`endif

    // Byte to send for the current state and position in the sequence.
    always_comb begin
        tx_rs   = 1'b0;
        tx_data = 8'h00;
        case (state_reg)
            ST_INIT: begin
                case (idx_reg)
                    5'd0:    tx_data = CMD_FUNC_SET;
                    5'd1:    tx_data = CMD_DISP_ON;
                    5'd2:    tx_data = CMD_CLEAR;
                    default: tx_data = CMD_ENTRY;
                endcase
            end
            ST_WRITE: begin
                if (idx_reg == 5'd0) begin
                    tx_data = CMD_LINE1;
                end else if (idx_reg <= 5'd8) begin
                    tx_rs   = 1'b1;
                    tx_data = line1_char[3'(idx_reg - 5'd1)];
                end
`ifdef LCD_BIN_LINE_EN
                else if (idx_reg == 5'd9) begin
                    tx_data = CMD_LINE2;
                end else begin
                    tx_rs   = 1'b1;
                    tx_data = bin_char[3'(idx_reg - 5'd10)];
                end
`endif
            end
            default: ;
        endcase
    end

    assign tx_clear = !tx_rs && (tx_data == CMD_CLEAR);
    assign tx_go    = tx_ready &&
                      (((state_reg == ST_INIT)  && (idx_reg < INIT_BYTES)) ||
                       ((state_reg == ST_WRITE) && (idx_reg < NBYTES)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_PWRUP;
            pwr_cnt_reg <= '0;
            idx_reg     <= '0;
            sel_reg     <= '0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                ST_PWRUP: begin
                    if (pwr_cnt_reg == POWERUP_CYC - 1) begin
                        state_reg <= ST_INIT;
                        idx_reg   <= '0;
                    end else begin
                        pwr_cnt_reg <= pwr_cnt_reg + 1;
                    end
                end
                ST_INIT: begin
                    if (tx_go) begin
                        idx_reg <= idx_reg + 5'd1;
                    end else if (tx_last && (idx_reg == INIT_BYTES)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        sel_reg    <= sel;
                        result_reg <= result;
                        idx_reg    <= '0;
                        state_reg  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Leave on the last wait cycle so done lands in the
                    // cycle right after the final byte's wait completes.
                    if (tx_go) begin
                        idx_reg <= idx_reg + 5'd1;
                    end else if (tx_last && (idx_reg == NBYTES)) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_PWRUP;
                end
            endcase
        end
    end

    lcd_byte_tx #(
        .E_HIGH_CYC (E_HIGH_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .CLEAR_CYC  (CLEAR_CYC)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .go       (tx_go),
        .rs       (tx_rs),
        .data     (tx_data),
        .is_clear (tx_clear),
        .ready    (tx_ready),
        .last     (tx_last),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_db   (lcd_db)
    );

    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_result_writer.sv
// Self-checking bench for lcd_result_writer with short timing parameters.
// A negedge monitor records every lcd_e strobe (byte, rise/fall cycle, bus
// value one cycle before the rise and at the fall) and every done pulse.
// Expected byte lists and strobe timing come from a small reference model
// built from the display format rules.
module tb_lcd_result_writer;

    localparam int PU = 16;
    localparam int EH = 2;
    localparam int ST = 4;
    localparam int CL = 8;
    localparam int T  = 2 + EH + ST;  // issue-to-issue spacing of a normal byte

`ifdef LCD_BIN_LINE_EN
    localparam int NB = 18;
`else
    localparam int NB = 9;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] sel = 4'h0;
    logic [7:0] result = 8'h00;
    logic       busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    lcd_result_writer #(
        .POWERUP_CYC (PU),
        .E_HIGH_CYC  (EH),
        .SETTLE_CYC  (ST),
        .CLEAR_CYC   (CL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sel    (sel),
        .result (result),
        .busy   (busy),
        .done   (done),
        .lcd_rs (lcd_rs),
        .lcd_rw (lcd_rw),
        .lcd_e  (lcd_e),
        .lcd_db (lcd_db)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    typedef struct {
        logic [8:0] b;      // {rs, db} while E high
        logic [8:0] su;     // {rs, db} one cycle before E rise
        logic [8:0] hd;     // {rs, db} in the first cycle after E fall
        int         rise;
        int         fall;
    } strobe_t;

    strobe_t    sq[$];
    int         dq[$];
    int         cyc = 0;
    logic       e_prev = 1'b0;
    logic [8:0] bus_prev = 9'h000;

    always @(negedge clk) begin
        strobe_t s;
        cyc = cyc + 1;
        if (lcd_e && !e_prev) begin
            s.b    = {lcd_rs, lcd_db};
            s.su   = bus_prev;
            s.hd   = 9'h000;
            s.rise = cyc;
            s.fall = -1;
            sq.push_back(s);
        end
        if (!lcd_e && e_prev && sq.size() > 0) begin
            sq[sq.size()-1].fall = cyc;
            sq[sq.size()-1].hd   = {lcd_rs, lcd_db};
        end
        if (done) dq.push_back(cyc);
        e_prev   = lcd_e;
        bus_prev = {lcd_rs, lcd_db};
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] hex_char(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    task automatic build_expected(input logic [3:0] s, input logic [7:0] r, output logic [8:0] eq[$]);
        eq.delete();
        eq.push_back({1'b0, 8'h80});
        eq.push_back({1'b1, 8'h53});
        eq.push_back({1'b1, 8'h3D});
        eq.push_back({1'b1, hex_char(int'(s))});
        eq.push_back({1'b1, 8'h20});
        eq.push_back({1'b1, 8'h52});
        eq.push_back({1'b1, 8'h3D});
        eq.push_back({1'b1, hex_char(int'(r) / 16)});
        eq.push_back({1'b1, hex_char(int'(r) % 16)});
`ifdef LCD_BIN_LINE_EN
        eq.push_back({1'b0, 8'hC0});
        for (int i = 7; i >= 0; i--) eq.push_back({1'b1, 8'(48 + ((int'(r) >> i) & 1))});
`endif
    endtask

    task automatic check_strobes(input string tag, input logic [8:0] eq[$], input int first_rise);
        chk({tag, "_count"}, sq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < sq.size(); i++) begin
            chk({tag, "_byte"},   sq[i].b,  eq[i]);
            chk({tag, "_setup"},  sq[i].su, eq[i]);
            chk({tag, "_hold"},   sq[i].hd, eq[i]);
            chk({tag, "_ewidth"}, sq[i].fall - sq[i].rise, EH);
            if (i == 0) chk({tag, "_first"}, sq[0].rise, first_rise);
            else chk({tag, "_spacing"}, sq[i].rise - sq[i-1].rise,
                     2 + EH + ((eq[i-1] == 9'h001) ? CL : ST));
        end
    endtask

    // Release reset and verify power-up hold, init strobes and busy fall.
    task automatic init_and_check();
        int c0;
        int tidle;
        logic [8:0] eq[$];
        rst = 1'b0;
        c0 = cyc;
        sq.delete();
        dq.delete();
        for (int i = 0; i <= PU; i++) begin
            chk("pwrup_hold", {busy, done, lcd_rs, lcd_rw, lcd_e, lcd_db}, 13'h1000);
            tick();
        end
        tidle = -1;
        for (int i = 0; i < 500 && tidle < 0; i++) begin
            if (!busy) tidle = cyc;
            else tick();
        end
        chk("init_idle_reached", 32'(tidle >= 0), 1);
        eq = '{9'h038, 9'h00C, 9'h001, 9'h006};
        check_strobes("init", eq, c0 + PU + 2);
        if (sq.size() >= 4) chk("init_busy_fall", tidle - sq[3].rise, EH + ST);
        chk("init_no_done", dq.size(), 0);
        $display("init: c0=%0d strobes=%0d idle_at=%0d", c0, sq.size(), tidle);
    endtask

    task automatic run_update(input logic [3:0] s, input logic [7:0] r, input bit disturb);
        logic [8:0] eq[$];
        int t0;
        int n;
        build_expected(s, r, eq);
        sq.delete();
        dq.delete();
        sel = s;
        result = r;
        start = 1'b1;
        t0 = cyc;
        tick();
        if (!disturb) start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        // With disturb, start stays high (including the done cycle) and the
        // inputs churn every cycle; none of it may affect this update.
        while (dq.size() == 0 && n < 1000) begin
            if (disturb) begin
                sel = 4'($urandom);
                result = 8'($urandom);
            end
            tick();
            n++;
        end
        chk("done_seen", 32'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
            chk("done_latency", dq[0] - t0, 1 + NB * T);
            chk("busy_in_done", busy, 1);
        end
        start = 1'b0;
        tick();
        chk("busy_after_done", busy, 0);
        repeat (20) tick();
        chk("done_pulses", dq.size(), 1);
        chk("idle_busy", busy, 0);
        check_strobes("upd", eq, t0 + 3);
        $display("update sel=%h result=%h disturb=%0d strobes=%0d", s, r, disturb, sq.size());
    endtask

    initial begin
        logic [3:0] rs_sel;
        logic [7:0] rs_res;
        repeat (3) tick();
        chk("reset_state", {busy, done, lcd_rs, lcd_rw, lcd_e, lcd_db}, 13'h1000);
        init_and_check();

        run_update(4'h2, 8'h0A, 1'b0);
        run_update(4'h8, 8'hFF, 1'b1);
        run_update(4'hF, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            rs_sel = 4'($urandom);
            rs_res = 8'($urandom);
            run_update(rs_sel, rs_res, 1'($urandom_range(0, 1)));
        end

        // Abort during the 5th data byte (6th strobe of the update).
        sq.delete();
        dq.delete();
        sel = 4'h3;
        result = 8'h5C;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 500 && sq.size() < 6; n++) tick();
        chk("abort_reached", 32'(sq.size() >= 6), 1);
        chk("abort_e_high", lcd_e, 1);
        rst = 1'b1;
        tick();
        chk("abort_e", lcd_e, 0);
        chk("abort_busy", busy, 1);
        chk("abort_done", done, 0);
        chk("abort_bus", {lcd_rs, lcd_db}, 9'h000);
        chk("abort_no_done", dq.size(), 0);
        $display("abort: reset applied after %0d strobes", sq.size());
        init_and_check();

        run_update(4'hA, 8'h05, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
